// File: rtl/store_buffer_lsu.sv
// store_buffer_lsu: load/store front end with a posted-store FIFO write buffer.
// Stores are buffered and drained to memory on cycles the memory port is not
// needed by a load. Loads return a registered response one cycle after accept.
// Optional feature macro: STORE_FWD_EN (defined = loads forward from the
// youngest matching buffered store; undefined = matching loads stall until
// the matching entries have drained).
module store_buffer_lsu #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 24,
  parameter int AW        = 12,
  parameter int DW        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  input  logic          flush,
  output logic          empty,
  output logic          MemWrite,
  output logic          MemRead,
  output logic [AW-1:0] address,
  output logic [DW-1:0] wd2,
  input  logic [DW-1:0] MemData_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Buffer storage and bookkeeping
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Registered response and status
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             empty_q, empty_d;

  // Request decode
  logic             is_load_s, is_store_s, in_range_s;
  logic             store_ok_s, load_ok_s;
  logic             load_acc_s, store_acc_s, push_s;
  logic             hit_s, use_fwd_s;
  logic [DW-1:0]    hit_data_s;
  logic             mem_read_s, drain_s;

  assign is_load_s  = req_valid & ~req_we;
  assign is_store_s = req_valid & req_we;
  assign in_range_s = (req_addr < AW'(MEM_WORDS));
  assign store_ok_s = (count_q < CW'(DEPTH)) & ~flush;

`ifdef STORE_FWD_EN
  assign load_ok_s = 1'b1;
  assign use_fwd_s = hit_s;
`else
  // Without forwarding a matching load waits for the buffer to drain past it
  assign load_ok_s = ~hit_s;
  assign use_fwd_s = 1'b0;
`endif

  assign load_acc_s  = is_load_s & load_ok_s;
  assign store_acc_s = is_store_s & store_ok_s;
  assign push_s      = store_acc_s & in_range_s;

  // Youngest-match search: walk from oldest to youngest so the last hit wins
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[rd_ptr_q + PW'(i)] && (addr_q[rd_ptr_q + PW'(i)] == req_addr)) begin
        hit_s      = 1'b1;
        hit_data_s = data_q[rd_ptr_q + PW'(i)];
      end else begin
        hit_s      = hit_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // Memory port arbitration: a missing in-range load wins, otherwise drain the head
  always_comb begin
    mem_read_s = load_acc_s & in_range_s & ~use_fwd_s;
    drain_s    = ~mem_read_s & (count_q != '0);
    MemRead    = mem_read_s;
    MemWrite   = drain_s;
    if (mem_read_s) begin
      address = req_addr;
      wd2     = '0;
    end else if (drain_s) begin
      address = addr_q[rd_ptr_q];
      wd2     = data_q[rd_ptr_q];
    end else begin
      address = '0;
      wd2     = '0;
    end
  end

  // Ready: loads limited only by the forwarding mode, stores by space and flush
  always_comb begin
    if (!req_valid) begin
      req_ready = 1'b1;
    end else if (req_we) begin
      req_ready = store_ok_s;
    end else begin
      req_ready = load_ok_s;
    end
  end

  // Pointer, occupancy and response next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (drain_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, drain_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d     = (count_d == '0);
    rsp_valid_d = load_acc_s;
    rsp_err_d   = (load_acc_s | store_acc_s) & ~in_range_s;
    if (load_acc_s && in_range_s) begin
      rsp_data_d = use_fwd_s ? hit_data_s : MemData_out;
    end else begin
      rsp_data_d = '0;
    end
  end

  // Buffer entries: invalidate the drained head, then fill the tail on a push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (drain_s) begin
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push_s) begin
        valid_q[wr_ptr_q] <= 1'b1;
        addr_q[wr_ptr_q]  <= req_addr;
        data_q[wr_ptr_q]  <= req_wdata;
      end
    end
  end

  // Pointers, count and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Bench for store_buffer_lsu: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_store_buffer_lsu;
  localparam int DEPTH = 4;
  localparam int MW    = 24;
  localparam int AW    = 12;
  localparam int DW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_we, flush;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, rsp_err, empty;
  logic [DW-1:0] rsp_data;
  logic          MemWrite, MemRead;
  logic [AW-1:0] address;
  logic [DW-1:0] wd2, MemData_out;

  store_buffer_lsu #(.DEPTH(DEPTH), .MEM_WORDS(MW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flush(flush), .empty(empty), .MemWrite(MemWrite), .MemRead(MemRead),
    .address(address), .wd2(wd2), .MemData_out(MemData_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 5);
  endfunction

  // Environment memory, written by the DUT's write strobe
  logic [DW-1:0] env_mem [0:31];
  logic          mem_load = 1'b1;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
    end else if (MemWrite) begin
      env_mem[address[4:0]] <= wd2;
    end
  end
  assign MemData_out = (address < AW'(MW)) ? env_mem[address[4:0]] : '0;

  // Reference model state
  logic [AW-1:0] mq_a[$];
  logic [DW-1:0] mq_d[$];
  logic [DW-1:0] m_mem [0:31];
  logic          e_rv, e_re;
  logic [DW-1:0] e_rd;
  logic          p_ready, p_mr, p_mw, p_push, n_rv, n_re;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd2, n_rd;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Predict this cycle's outputs and next response from the current inputs
  task automatic model_eval();
    bit hit = 1'b0;
    logic [DW-1:0] hd = '0;
    bit inr, lacc, sacc, load_ok;
    int n = mq_a.size();
    for (int i = 0; i < n; i++) begin
      if (mq_a[i] == req_addr) begin hit = 1'b1; hd = mq_d[i]; end
    end
    inr = (req_addr < AW'(MW));
`ifdef STORE_FWD_EN
    load_ok = 1'b1;
`else
    load_ok = !hit;
`endif
    if (!req_valid) p_ready = 1'b1;
    else if (req_we) p_ready = (n < DEPTH) && !flush;
    else p_ready = load_ok;
    lacc = req_valid && !req_we && p_ready;
    sacc = req_valid && req_we && p_ready;
    p_mr = lacc && inr && !hit;
    p_mw = !p_mr && (n > 0);
    p_addr = '0;
    p_wd2  = '0;
    if (p_mr) p_addr = req_addr;
    else if (p_mw) begin p_addr = mq_a[0]; p_wd2 = mq_d[0]; end
    p_push = sacc && inr;
    n_rv = lacc;
    n_re = (lacc || sacc) && !inr;
    n_rd = '0;
    if (lacc && inr) n_rd = hit ? hd : m_mem[req_addr[4:0]];
  endtask

  task automatic model_commit();
    if (p_mw) begin
      m_mem[mq_a[0][4:0]] = mq_d[0];
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (p_push) begin
      mq_a.push_back(req_addr);
      mq_d.push_back(req_wdata);
    end
    e_rv = n_rv; e_re = n_re; e_rd = n_rd;
  endtask

  task automatic compare_all();
    chk("req_ready", req_ready, p_ready);
    chk("MemRead", MemRead, p_mr);
    chk("MemWrite", MemWrite, p_mw);
    chk("address", address, p_addr);
    chk("wd2", wd2, p_wd2);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_err", rsp_err, e_re);
    chk("rsp_data", rsp_data, e_rd);
    chk("empty", empty, mq_a.size() == 0);
  endtask

  task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit fl);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; flush = fl;
    model_eval();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] a);
    int k = 0;
    step(1'b1, 1'b0, a, '0, 1'b0);
    while (!p_ready && k < 8) begin
      tick();
      step(1'b1, 1'b0, a, '0, 1'b0);
      k++;
    end
    chk("load_accepted", req_ready, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    req_valid = 1'b0; req_we = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #1;
    mq_a.delete(); mq_d.delete();
    e_rv = 1'b0; e_re = 1'b0; e_rd = '0;
    model_eval();
    compare_all();
    chk("rst_empty", empty, 1'b1);
    chk("rst_MemWrite", MemWrite, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; flush = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
    e_rv = 1'b0; e_re = 1'b0; e_rd = '0;
    @(posedge clk);
    #1;
    mem_load = 1'b0;
    // Reset state
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_empty", empty, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_address", address, 12'h000);
    tick();
    reset = 1'b1;

    // Store then immediate load of the same address
    step(1'b1, 1'b1, 12'd5, 12'hABC, 1'b0);
    chk("A_store_ready", req_ready, 1'b1);
    chk("A_store_nowrite", MemWrite, 1'b0);
    tick();
    step(1'b1, 1'b0, 12'd5, '0, 1'b0);
`ifdef STORE_FWD_EN
    chk("A_fwd_ready", req_ready, 1'b1);
    chk("A_fwd_noread", MemRead, 1'b0);
    tick();
`else
    chk("A_stall_ready", req_ready, 1'b0);
    chk("A_stall_drain", MemWrite, 1'b1);
    chk("A_stall_addr", address, 12'd5);
    chk("A_stall_wd2", wd2, 12'hABC);
    tick();
    step(1'b1, 1'b0, 12'd5, '0, 1'b0);
    chk("A_load_ready", req_ready, 1'b1);
    chk("A_load_read", MemRead, 1'b1);
    tick();
`endif
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("A_rsp_valid", rsp_valid, 1'b1);
    chk("A_rsp_data", rsp_data, 12'hABC);
    tick();

    // Youngest match wins
    step(1'b1, 1'b1, 12'd3, 12'h111, 1'b0); tick();
    step(1'b1, 1'b1, 12'd3, 12'h222, 1'b0); tick();
    do_load(12'd3);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("B_rsp_data", rsp_data, 12'h222);
    tick();

    // Out-of-range store and load
    step(1'b1, 1'b1, 12'd30, 12'h777, 1'b0);
    chk("C_store_ready", req_ready, 1'b1);
    tick();
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("C_err_pulse", rsp_err, 1'b1);
    chk("C_err_novalid", rsp_valid, 1'b0);
    chk("C_no_write", MemWrite, 1'b0);
    tick();
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("C_err_once", rsp_err, 1'b0);
    tick();
    step(1'b1, 1'b0, 12'd24, '0, 1'b0);
    chk("C_oob_noread", MemRead, 1'b0);
    tick();
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("C_oob_valid", rsp_valid, 1'b1);
    chk("C_oob_data", rsp_data, 12'h000);
    chk("C_oob_err", rsp_err, 1'b1);
    tick();

    // Flush blocks stores while the buffer drains
    step(1'b1, 1'b1, 12'd6, 12'h333, 1'b0); tick();
    step(1'b1, 1'b1, 12'd9, 12'h444, 1'b1);
    chk("D_flush_block", req_ready, 1'b0);
    chk("D_flush_drain", MemWrite, 1'b1);
    chk("D_flush_addr", address, 12'd6);
    tick();
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("D_flush_empty", empty, 1'b1);
    tick();
    step(1'b1, 1'b1, 12'd9, 12'h444, 1'b0);
    chk("D_unflush_ready", req_ready, 1'b1);
    tick();

    // Reset with a buffered entry discards it
    step(1'b1, 1'b1, 12'd7, 12'h555, 1'b0); tick();
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("E_no_write_after_reset", MemWrite, 1'b0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic [AW-1:0] a;
        if ($urandom_range(0, 15) < 12) a = AW'($urandom_range(0, 7));
        else a = AW'($urandom_range(0, 31));
        step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), a,
             DW'($urandom), $urandom_range(0, 9) == 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer_lsu.md
Name: store_buffer_lsu

Overview:
Load/store front end between the CPU execute stage and the 12-bit data memory. Accepts one load or store request per cycle from the CPU. Posts stores into a small FIFO write buffer that drains to memory on idle memory cycles. Serves loads from the youngest matching buffered store, or from memory, and returns each load response one cycle after acceptance.

Parameters:
DEPTH, 4, write-buffer entries; power of two, 2..8
MEM_WORDS, 24, legal data-memory word count; addresses >= MEM_WORDS are out of range
AW, 12, address width
DW, 12, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  CPU request present
req_we  in  1  1 = store, 0 = load
req_addr  in  AW  word address
req_wdata  in  DW  store data
req_ready  out  1  request accepted this cycle when req_valid & req_ready
rsp_valid  out  1  load data valid (one-cycle pulse)
rsp_data  out  DW  load data
rsp_err  out  1  pulses with rsp_valid for an out-of-range load, and alone for an out-of-range store
flush  in  1  stop accepting stores until the buffer is empty
empty  out  1  write buffer empty
MemWrite  out  1  memory write strobe
MemRead  out  1  memory read enable
address  out  AW  memory address
wd2  out  DW  memory write data
MemData_out  in  DW  combinational read data from memory

Behaviour:
- Reset (reset=0, async): FIFO pointers and count cleared; all entries invalid. Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, empty=1, MemWrite=0, MemRead=0, address=0, wd2=0.
- FIFO: DEPTH entries of {addr, data}; wr_ptr, rd_ptr wrap modulo DEPTH; count ranges 0..DEPTH.
- Store accept: requires count<DEPTH and flush=0.
  - In-range store: pushed at wr_ptr.
  - Out-of-range store: not pushed; rsp_err=1 on the next cycle, rsp_valid stays 0.
- Load accept: always accepted, except as limited in the Optional Feature section.
- req_ready:
  - Load: 1.
  - Store: (count<DEPTH) & ~flush.
- Memory port arbitration per cycle:
  - Accepted load, no buffer hit, in range: MemRead=1, address=req_addr, MemWrite=0.
  - Otherwise, if count>0: drain the head entry: MemWrite=1, address=head.addr, wd2=head.data, rd_ptr++.
  - Idle: MemRead=0, MemWrite=0, address=0, wd2=0.
  - The memory port is combinational from the current state and request.
- Load data source:
  - Buffer hit: data of the youngest valid entry with addr==req_addr (search from wr_ptr-1 back to rd_ptr). The entry being drained in the same cycle still counts as valid.
  - Miss: MemData_out.
  - Out-of-range load: data 0, rsp_err=1.
  - The result is registered; rsp_valid=1 exactly one cycle after acceptance.
- Simultaneous push and drain in one cycle: count unchanged.
- Full buffer with a store request: req_ready=0. The head drains that cycle if no load is present; req_ready rises the following cycle.
- Continuous loads starve draining. Fairness is not required, but stores stall once the buffer is full.
- empty = (count==0), registered from count.
- Reset asserted mid-operation: buffered stores are discarded and are not written to memory.

Optional Feature:
- Macro STORE_FWD_EN.
- Defined: loads forward from the buffer as described in Behaviour.
- Undefined: no forwarding. A load whose address matches any valid entry gets req_ready=0 and is held until no match remains; draining continues during the stall. A non-matching load proceeds to memory as normal.

Test Plan:
- Store (addr 5, 0xABC), then load addr 5 in the next cycle.
  - With STORE_FWD_EN: rsp_data=0xABC one cycle later, MemRead=0.
  - Without STORE_FWD_EN: load stalls one cycle while the entry drains, then rsp_data=0xABC.
- Stores to addr 3 (0x111) then addr 3 (0x222), then load addr 3 -> rsp_data=0x222 (youngest-match forwarding).
- Four stores with DEPTH=4 while loads keep the memory port busy -> fifth store sees req_ready=0. Remove the loads -> one drain per cycle, MemWrite writes to addresses in order, empty=1 after 4 cycles.
- Store to addr 30 -> rsp_err pulses once, no MemWrite ever. Load addr 24 -> rsp_valid=1, rsp_data=0, rsp_err=1.
- Assert flush with 3 entries buffered -> stores blocked; empty=1 after 3 drain cycles; req_ready for stores returns once flush is deasserted.
- Assert reset with 2 entries buffered -> empty=1 and all outputs at reset values immediately; no MemWrite after reset is released.
